// File: rtl/fft_stage_ctrl_pkg.sv
// Shared types and latency constants for the FFT stage controller.
// Latencies count cycles from an input pair to the matching registered output.
package fft_stage_ctrl_pkg;

    localparam int N_PT    = 32;
    localparam int TOT_LAT = 39;
    localparam int L1      = 8;
    localparam int L2      = 24;
    localparam int L3      = 32;
    localparam int L4      = 36;
    localparam int L5      = 38;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic [3:0] idx;
        logic [2:0] fid;
    } tag_t;

endpackage

// File: rtl/fft_tag_pipe.sv
// Frame-tag delay line; taps show the tag after any same-cycle frame clear,
// so the clear also hides the aborted frame from the consumers' registers.
module fft_tag_pipe
    import fft_stage_ctrl_pkg::*;
#(
    parameter int DEPTH = TOT_LAT - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  tag_t             i_tag,
    input  logic             i_clr,
    input  logic [2:0]       i_clr_fid,
    output tag_t [DEPTH-1:0] o_tap,
    output logic             o_live
);

    tag_t [DEPTH-1:0] r_tag;
    tag_t [DEPTH-1:0] w_keep;

    always_comb begin
        w_keep = r_tag;
        o_live = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_clr && r_tag[k].valid && r_tag[k].fid == i_clr_fid)
                w_keep[k] = '0;
            o_live = o_live | w_keep[k].valid;
        end
    end

    assign o_tap = w_keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++)
                r_tag[k] <= w_keep[k-1];
        end
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Frame FSM plus per-stage butterfly/commutator/twiddle controls for a
// 5-stage pipelined FFT, all derived from a delayed frame-tag line.
module fft_stage_ctrl #(
    parameter int N_PT    = fft_stage_ctrl_pkg::N_PT,
    parameter int TOT_LAT = fft_stage_ctrl_pkg::TOT_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sop,
    output logic [4:0] state_com_mode,
    output logic [4:0] butter_mode,
    output logic [4:0] mul_mode,
    output logic [6:0] state_code,
    output logic [2:0] rom_8_counter,
    output logic       out_valid,
    output logic       out_sop,
    output logic       busy,
    output logic       frame_err
);
    import fft_stage_ctrl_pkg::*;

    localparam int         DEPTH    = TOT_LAT - 1;
    localparam int         FW       = $clog2(TOT_LAT);
    localparam logic [3:0] IDX_LAST = 4'(N_PT / 2 - 1);

    state_t        r_state, w_state;
    logic [3:0]    r_idx, w_idx;
    logic [2:0]    r_cur_fid, w_cur_fid;
    logic [2:0]    r_next_fid, w_next_fid;
    logic [FW-1:0] r_flush, w_flush;
    tag_t          w_push;
    logic          w_clr, w_err, w_start, w_live;
    tag_t [DEPTH-1:0] w_tap;
    tag_t          w_s1, w_s2, w_s3, w_s4, w_s5, w_out;
    logic          w_unused;

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_cur_fid  = r_cur_fid;
        w_next_fid = r_next_fid;
        w_flush    = r_flush;
        w_push     = '0;
        w_clr      = 1'b0;
        w_err      = 1'b0;
        w_start    = 1'b0;
        unique case (r_state)
            S_IDLE: w_start = in_valid & in_sop;
            S_RUN: begin
                if (r_idx == IDX_LAST) begin
                    if (in_valid && in_sop) w_start = 1'b1;
                    else w_state = S_IDLE;
                end else if (in_valid) begin
                    // a stray sop mid-frame is carried as plain data
                    w_idx        = r_idx + 4'd1;
                    w_push.valid = 1'b1;
                    w_push.idx   = r_idx + 4'd1;
                    w_push.fid   = r_cur_fid;
                    w_err        = in_sop;
                end else begin
                    w_err   = 1'b1;
                    w_clr   = 1'b1;
                    w_state = S_FLUSH;
                    w_flush = FW'(TOT_LAT - 1);
                end
            end
            S_FLUSH: begin
                w_err = in_valid & in_sop;
                if (r_flush == '0) w_state = S_IDLE;
                else w_flush = r_flush - FW'(1);
            end
            default: w_state = S_IDLE;
        endcase
        if (w_start) begin
            w_state      = S_RUN;
            w_idx        = '0;
            w_cur_fid    = r_next_fid;
            w_next_fid   = r_next_fid + 3'd1;
            w_push.valid = 1'b1;
            w_push.sop   = 1'b1;
            w_push.fid   = r_next_fid;
        end
    end

    fft_tag_pipe #(
        .DEPTH(DEPTH)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_tag    (w_push),
        .i_clr    (w_clr),
        .i_clr_fid(r_cur_fid),
        .o_tap    (w_tap),
        .o_live   (w_live)
    );

    // one tap early: the output register supplies the final cycle
    assign w_s1  = w_tap[L1-2];
    assign w_s2  = w_tap[L2-2];
    assign w_s3  = w_tap[L3-2];
    assign w_s4  = w_tap[L4-2];
    assign w_s5  = w_tap[L5-2];
    assign w_out = w_tap[TOT_LAT-2];

    assign w_unused = ^w_tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_cur_fid      <= '0;
            r_next_fid     <= '0;
            r_flush        <= '0;
            state_com_mode <= '0;
            butter_mode    <= '0;
            mul_mode       <= '0;
            state_code     <= '0;
            rom_8_counter  <= '0;
            out_valid      <= 1'b0;
            out_sop        <= 1'b0;
            busy           <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cur_fid  <= w_cur_fid;
            r_next_fid <= w_next_fid;
            r_flush    <= w_flush;
            butter_mode <= {w_s5.valid, w_s4.valid, w_s3.valid,
                            w_s2.valid, w_s1.valid};
            mul_mode    <= {1'b0, w_s4.valid, w_s3.valid,
                            w_s2.valid, w_s1.valid};
            state_com_mode <= {w_s5.valid & w_s5.idx[0],
                               w_s4.valid & w_s4.idx[1],
                               w_s3.valid & w_s3.idx[2],
                               w_s2.valid & w_s2.idx[3],
                               1'b0};
            rom_8_counter <= w_s2.valid ? w_s2.idx[2:0] : 3'd0;
            state_code    <= w_s2.valid ? {w_s2.fid, w_s2.idx} : 7'd0;
            out_valid     <= w_out.valid;
            out_sop       <= w_out.valid & w_out.sop;
            busy          <= (w_state != S_IDLE) | w_push.valid | w_live;
            frame_err     <= w_err;
        end
    end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: directed frame scenarios plus random traffic,
// checked each cycle against a per-pair history model.
module tb_fft_stage_ctrl;

    localparam int MAXC = 4096;
    localparam int TOT  = 39;
    localparam int BIG  = 32'h7fffffff;
    localparam int LAT [5] = '{8, 24, 32, 36, 38};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic [4:0] state_com_mode, butter_mode, mul_mode;
    logic [6:0] state_code;
    logic [2:0] rom_8_counter;
    logic       out_valid, out_sop, busy, frame_err;

    int n_chk  = 0;
    int n_pass = 0;

    // model: one history entry per clock edge, killed from a given edge on
    int         m = 0;
    int         mode = 0;
    int         pos = 0;
    int         cur = 0;
    int         nfid = 0;
    int         left = 0;
    bit         err_e = 1'b0;
    bit         hv [MAXC];
    bit         hs [MAXC];
    logic [3:0] hi [MAXC];
    logic [2:0] hf [MAXC];
    int         kill [MAXC];

    fft_stage_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_sop        (in_sop),
        .state_com_mode(state_com_mode),
        .butter_mode   (butter_mode),
        .mul_mode      (mul_mode),
        .state_code    (state_code),
        .rom_8_counter (rom_8_counter),
        .out_valid     (out_valid),
        .out_sop       (out_sop),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h, expected %0h",
                      tag, m, got, exp);
    endtask

    function automatic bit live(input int n);
        return n >= 1 && n <= m && hv[n] && kill[n] > m;
    endfunction

    task automatic record(input bit s, input int idx, input int fid);
        hv[m] = 1'b1;
        hs[m] = s;
        hi[m] = 4'(idx);
        hf[m] = 3'(fid);
    endtask

    task automatic start_frame();
        mode = 1;
        pos  = 0;
        cur  = nfid;
        nfid = (nfid + 1) % 8;
        record(1'b1, 0, cur);
    endtask

    task automatic model_step(input bit v, input bit s);
        m++;
        hv[m]   = 1'b0;
        kill[m] = BIG;
        err_e   = 1'b0;
        if (rst) begin
            mode = 0; pos = 0; cur = 0; nfid = 0; left = 0;
            for (int n = 0; n <= m; n++) hv[n] = 1'b0;
            return;
        end
        if (mode == 0) begin
            if (v && s) start_frame();
        end else if (mode == 1) begin
            if (pos == 15) begin
                if (v && s) start_frame();
                else mode = 0;
            end else if (v) begin
                pos++;
                record(1'b0, pos, cur);
                err_e = s;
            end else begin
                err_e = 1'b1;
                for (int n = m - 41; n < m; n++)
                    if (n >= 1 && hv[n] && hf[n] == 3'(cur)) kill[n] = m;
                mode = 2;
                left = TOT;
            end
        end else begin
            err_e = v && s;
            left--;
            if (left == 0) mode = 0;
        end
    endtask

    task automatic compare();
        logic [4:0] eb, em, ec;
        logic [2:0] erom;
        logic [6:0] esc;
        bit         eov, eos, ebusy;
        int         n;
        eb = '0; ec = '0; erom = '0; esc = '0;
        for (int s = 0; s < 5; s++) begin
            n = m - LAT[s] + 1;
            eb[s] = live(n);
            if (s > 0 && eb[s]) ec[s] = hi[n][4-s];
        end
        em = {1'b0, eb[3:0]};
        n = m - LAT[1] + 1;
        if (live(n)) begin
            erom = hi[n][2:0];
            esc  = {hf[n], hi[n]};
        end
        n = m - TOT + 1;
        eov = live(n);
        eos = eov && hs[n];
        ebusy = (mode != 0);
        for (int k = m - TOT + 1; k <= m; k++)
            if (live(k)) ebusy = 1'b1;
        check("butter_mode", butter_mode, eb);
        check("mul_mode", mul_mode, em);
        check("state_com_mode", state_com_mode, ec);
        check("rom_8_counter", rom_8_counter, erom);
        check("state_code", state_code, esc);
        check("out_valid", out_valid, eov);
        check("out_sop", out_sop, eos);
        check("busy", busy, ebusy);
        check("frame_err", frame_err, err_e);
    endtask

    task automatic tick(input bit v, input bit s);
        in_valid = v;
        in_sop   = s;
        @(posedge clk);
        model_step(v, s);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic send_frame(input int npairs, input int abort_at,
                              input int extra_sop);
        for (int i = 0; i < npairs; i++) begin
            if (i == abort_at) begin
                tick(1'b0, 1'b0);
                return;
            end
            tick(1'b1, i == 0 || i == extra_sop);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        #1;
        check("rst_butter_mode", butter_mode, 0);
        check("rst_state_code", state_code, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        idle(3);
        rst = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < MAXC; n++) begin
            hv[n] = 1'b0;
            kill[n] = BIG;
        end
        @(negedge clk);
        do_reset();

        // single frame right after reset release
        send_frame(16, -1, -1);
        idle(45);
        // three back-to-back frames
        idle($urandom_range(3, 9));
        for (int f = 0; f < 3; f++) send_frame(16, -1, -1);
        idle(45);
        // full frame then a frame dropping valid at idx 5
        idle($urandom_range(3, 9));
        send_frame(16, -1, -1);
        send_frame(16, 5, -1);
        idle(50);
        // stray sop at idx 9
        send_frame(16, -1, 9);
        idle(45);
        // reset mid-frame at idx 7, then a clean frame
        send_frame(8, -1, -1);
        do_reset();
        send_frame(16, -1, -1);
        idle(45);
        // nine consecutive frames: frame id wraps
        for (int f = 0; f < 9; f++) send_frame(16, -1, -1);
        idle(45);
        // random traffic, including sop without valid and sop in flush
        for (int i = 0; i < 700; i++)
            tick($urandom_range(0, 99) < 94, $urandom_range(0, 99) < 10);
        idle(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter N_PT, default 32, points per frame (fixed; other values unsupported).
REQ-002 SHALL have parameter TOT_LAT, default 39, cycles from frame cycle n at input to output pair n.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input sample pair present this cycle.
REQ-006 in_sop  input  1  first pair of a frame; qualified by in_valid.
REQ-007 state_com_mode  output  5  bit k = commutator swap for stage k+1.
REQ-008 butter_mode  output  5  bit k = stage k+1 butterfly active.
REQ-009 mul_mode  output  5  bit k = stage k+1 twiddle multiply enabled.
REQ-010 state_code  output  7  {frame_id[2:0], stage-2 local index[3:0]}.
REQ-011 rom_8_counter  output  3  stage-2 twiddle ROM address.
REQ-012 out_valid, out_sop  output  1 each  output pair valid / first pair of frame.
REQ-013 busy  output  1  any valid tag in pipeline or FSM not IDLE.
REQ-014 frame_err  output  1  one-cycle pulse on protocol violation.

Function
REQ-015 SHALL implement FSM IDLE, RUN, FLUSH; IDLE->RUN on in_valid&in_sop; RUN stays while in_valid; RUN->IDLE after idx 15 with no new sop; RUN->RUN (back-to-back) on in_valid&in_sop in the cycle after idx 15.
REQ-016 SHALL keep 4-bit input index idx, 0 at sop, +1 per valid cycle, 15 ends frame; 3-bit frame_id increments per accepted sop, wraps 7->0.
REQ-017 SHALL push tag {valid, sop, idx, frame_id} into a TOT_LAT-deep tag pipeline every cycle (valid=0 when no data).
REQ-018 Stage butterfly latencies from input (package constants) SHALL be L1=8, L2=24, L3=32, L4=36, L5=38; stage s local tag = tag pipeline tap L_s.
REQ-019 butter_mode[s-1] SHALL equal local tag valid of stage s.
REQ-020 state_com_mode[0] SHALL be 0; bits 1..4 SHALL equal local idx bit 3,2,1,0 of stages 2..5, gated by that stage's tag valid.
REQ-021 mul_mode[s-1] SHALL be high when stage s tag valid and s<=4; mul_mode[4] SHALL be 0 (last stage has no twiddle).
REQ-022 rom_8_counter SHALL equal stage-2 local idx[2:0]; state_code SHALL be {stage-2 frame_id, stage-2 idx}; both 0 when stage-2 tag invalid.
REQ-023 out_valid/out_sop SHALL be tap TOT_LAT valid/sop; first pair of a frame accepted at cycle t0 appears at t0+39.
REQ-024 in_valid low while RUN with idx not 15: frame_err pulse, FSM->FLUSH, all tags bearing the aborted frame_id cleared to valid=0 same cycle; earlier frames unaffected.
REQ-025 FLUSH SHALL ignore inputs; sop during FLUSH raises frame_err; FLUSH->IDLE when no tag of aborted frame remains (fixed TOT_LAT cycles).
REQ-026 in_sop during RUN with idx not 15: frame_err pulse, sop treated as ordinary data, idx continues.
REQ-027 in_sop without in_valid SHALL be ignored, no error.
REQ-028 All outputs SHALL be registered; no combinational path input->output.

Reset
REQ-029 On rst: FSM IDLE, idx 0, frame_id 0, all tags invalid, every output 0; takes effect immediately, mid-frame data is lost.
REQ-030 First sop accepted SHALL be the first cycle after rst deasserts.

Structure
REQ-031 Shared package SHALL hold FSM state enum, tag struct, L1..L5, TOT_LAT, N_PT.
REQ-032 Tag delay line SHALL be one sub-module, fft_tag_pipe, with per-frame_id clear port.

Verification
REQ-033 Single frame: sop at cycle 10, 16 valid -> butter_mode[1] high cycles 34..49, rom_8_counter 0..7,0..7, out_sop at 49, out_valid 49..64.
REQ-034 Back-to-back 3 frames -> out_valid continuous 48 cycles, out_sop every 16, state_code frame_id 0,1,2.
REQ-035 in_valid drops at idx 5 of frame 1 after full frame 0 -> frame_err 1 cycle, frame 0 fully output, frame 1 produces no out_valid, FSM IDLE after 39 cycles.
REQ-036 Extra sop at idx 9 -> frame_err pulse, out_valid still 16 contiguous, out_sop once.
REQ-037 rst asserted mid-frame at idx 7 -> all outputs 0 next edge-independent instant, busy 0, new sop after release behaves per REQ-033.
REQ-038 Nine consecutive frames -> frame_id wraps 7->0, state_code[6:4] = 0 on ninth.
